// File: rtl/sd_emmc_sync_fifo_pkg.sv
// Shared helpers for the SD/eMMC sync FIFO: constant clog2 and byte parity.
package sd_emmc_sync_fifo_pkg;

  localparam int BYTE_W = 8;

  // Ceiling log2 usable in constant expressions (localparams, widths).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Even-parity bit for one byte: word plus this bit has an even count of ones.
  function automatic logic par8(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sd_emmc_sync_fifo_if.sv
// Handshake/data bundle between the SD/eMMC sync FIFO and its user.
// master = producer/consumer side, slave = the FIFO itself.
interface sd_emmc_sync_fifo_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              underflow;
  logic              parity_err;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, almost_full, almost_empty, level,
           overflow, underflow, parity_err
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, almost_full, almost_empty, level,
           overflow, underflow, parity_err
  );
endinterface

// File: rtl/sd_emmc_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// Written so synthesis maps it onto block RAM.
module sd_emmc_sdp_ram
  import sd_emmc_sync_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Registered read port; holds the last word when not enabled.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sd_emmc_sync_fifo.sv
// SD/eMMC single-clock FWFT FIFO: RAM + prefetch stage + output register,
// level counter, threshold flags, sticky errors and synchronous flush.
// Optional byte parity on the RAM path: define SD_EMMC_FIFO_PARITY_EN.
module sd_emmc_sync_fifo
  import sd_emmc_sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 512,
  parameter int AF_THRESH = 448,
  parameter int AE_THRESH = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  sd_emmc_sync_fifo_if.slave  bus
);
  localparam int AW    = clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int PAR_W = DATA_W / BYTE_W;
`ifdef SD_EMMC_FIFO_PARITY_EN
  localparam int RAM_W = DATA_W + PAR_W;
`else
  localparam int RAM_W = DATA_W;
`endif

  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d, ram_cnt;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, full_d, af_q, af_d, ae_q, ae_d;
  logic              s1_vld_q, s1_vld_d, out_vld_q, out_vld_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, perr_q, perr_d;
  logic              push, pop, s1_adv, ram_rd, par_bad;
  logic [RAM_W-1:0]  ram_wdata, ram_rdata;

  // full is the registered flag, so a push while full is dropped even when
  // a pop is accepted in the same cycle.
  assign push    = bus.wr_en && !full_q;
  assign pop     = bus.rd_en && out_vld_q;
  assign ram_cnt = wptr_q - rptr_q;
  // Prefetch word moves to the output register when that register is free.
  assign s1_adv  = s1_vld_q && (!out_vld_q || pop);
  // Issue a RAM read whenever the prefetch stage will be free next cycle.
  assign ram_rd  = (ram_cnt != '0) && (!s1_vld_q || s1_adv);

`ifdef SD_EMMC_FIFO_PARITY_EN
  logic [PAR_W-1:0] wpar, rpar;
  for (genvar b = 0; b < PAR_W; b++) begin : g_par
    assign wpar[b] = par8(bus.wr_data[BYTE_W*b +: BYTE_W]);
    assign rpar[b] = par8(ram_rdata[BYTE_W*b +: BYTE_W]);
  end
  assign ram_wdata = {wpar, bus.wr_data};
  assign par_bad   = s1_adv && (rpar != ram_rdata[DATA_W +: PAR_W]);
`else
  assign ram_wdata = bus.wr_data;
  assign par_bad   = 1'b0;
`endif

  sd_emmc_sdp_ram #(.WIDTH(RAM_W), .DEPTH(DEPTH)) u_ram (
    .clk_i   (aclk),
    .we_i    (push && !bus.flush),
    .waddr_i (wptr_q),
    .wdata_i (ram_wdata),
    .re_i    (ram_rd && !bus.flush),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  // Next state for pointers, level, flags, pipeline and errors; flush wins.
  always_comb begin
    wptr_d    = wptr_q + AW'(push);
    rptr_d    = rptr_q + AW'(ram_rd);
    level_d   = level_q + LW'(push) - LW'(pop);
    full_d    = (level_d == LW'(DEPTH));
    af_d      = (level_d >= LW'(AF_THRESH));
    ae_d      = (level_d <= LW'(AE_THRESH));
    s1_vld_d  = ram_rd ? 1'b1 : (s1_adv ? 1'b0 : s1_vld_q);
    out_vld_d = s1_adv ? 1'b1 : (pop ? 1'b0 : out_vld_q);
    rd_data_d = s1_adv ? ram_rdata[DATA_W-1:0] : rd_data_q;
    ovf_d     = ovf_q  | (bus.wr_en && full_q);
    unf_d     = unf_q  | (bus.rd_en && !out_vld_q);
    perr_d    = perr_q | par_bad;
    if (bus.flush) begin
      wptr_d    = '0;
      rptr_d    = '0;
      level_d   = '0;
      full_d    = 1'b0;
      af_d      = 1'b0;
      ae_d      = 1'b1;
      s1_vld_d  = 1'b0;
      out_vld_d = 1'b0;
      rd_data_d = '0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      perr_d    = 1'b0;
    end
  end

  // State registers with async reset to the empty state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      s1_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      s1_vld_q  <= s1_vld_d;
      out_vld_q <= out_vld_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      perr_q    <= perr_d;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = out_vld_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
  assign bus.parity_err   = perr_q;
endmodule
